// File: rtl/chronos.sv
// Shared Chronos task-unit types used across tiles.
package chronos;

  typedef logic [31:0] task_t;
  typedef logic [3:0]  tsb_entry_id_t;
  typedef logic [7:0]  epoch_t;
  typedef logic [5:0]  tq_slot_t;
  typedef logic [3:0]  tile_id_t;

  // Response returned to the originating tile's task-send buffer.
  typedef struct packed {
    logic          ack;
    tsb_entry_id_t tsb_id;
    epoch_t        epoch;
    tq_slot_t      tq_slot;
    tile_id_t      dest_tile;
  } task_resp_t;

endpackage

// File: rtl/task_enq_responder_pkg.sv
// Local types and helpers for the task-enqueue responder.
package task_enq_responder_pkg;
  import chronos::*;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } enq_state_e;

  // Builds a response word; nacks carry zero epoch and slot.
  function automatic task_resp_t make_resp(input logic          ack,
                                           input tsb_entry_id_t tsb_id,
                                           input epoch_t        epoch,
                                           input tq_slot_t      slot,
                                           input tile_id_t      dest);
    task_resp_t r;
    r.ack       = ack;
    r.tsb_id    = tsb_id;
    r.epoch     = ack ? epoch : '0;
    r.tq_slot   = ack ? slot : '0;
    r.dest_tile = dest;
    return r;
  endfunction

endpackage

// File: rtl/task_enq_responder_if.sv
// Request, TQ-enqueue and response channels of the destination-tile responder.
interface task_enq_responder_if;
  import chronos::*;

  // Incoming enqueue requests from remote task-send buffers
  logic          req_valid;
  logic          req_ready;
  task_t         req_data;
  logic          req_tied;
  tsb_entry_id_t req_tsb_id;
  tile_id_t      req_src_tile;

  // Local task queue enqueue port
  logic          tq_enq_valid;
  logic          tq_enq_ready;
  task_t         tq_enq_data;
  logic          tq_enq_tied;
  tq_slot_t      tq_enq_slot;
  epoch_t        tq_enq_epoch;
  logic          tq_full;

  // Responses back to the originating tile
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_ack;
  tsb_entry_id_t resp_tsb_id;
  epoch_t        resp_epoch;
  tq_slot_t      resp_tq_slot;
  tile_id_t      resp_dest_tile;

  // Environment side: network, task queue and response sink
  modport master (
    output req_valid, req_data, req_tied, req_tsb_id, req_src_tile,
    output tq_enq_ready, tq_enq_slot, tq_enq_epoch, tq_full,
    output resp_ready,
    input  req_ready,
    input  tq_enq_valid, tq_enq_data, tq_enq_tied,
    input  resp_valid, resp_ack, resp_tsb_id, resp_epoch, resp_tq_slot, resp_dest_tile
  );

  // Responder side
  modport slave (
    input  req_valid, req_data, req_tied, req_tsb_id, req_src_tile,
    input  tq_enq_ready, tq_enq_slot, tq_enq_epoch, tq_full,
    input  resp_ready,
    output req_ready,
    output tq_enq_valid, tq_enq_data, tq_enq_tied,
    output resp_valid, resp_ack, resp_tsb_id, resp_epoch, resp_tq_slot, resp_dest_tile
  );

endinterface

// File: rtl/task_enq_responder_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through output.
// The head word lives in an output register; the rest sit in an array that is
// read synchronously into that register, so the array maps onto block RAM.
module task_enq_responder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    mem_cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic pop_eff;
  logic out_free;
  logic mem_has;
  logic mem_wr;
  logic mem_rd;

  // Decide where a push lands and whether the head register refills this cycle
  always_comb begin
    pop_eff  = pop_i & out_valid_q;
    out_free = ~out_valid_q | pop_eff;
    mem_has  = (mem_cnt_q != '0);
    mem_rd   = out_free & mem_has;
    // A push bypasses the array only when the head is free and nothing is queued ahead
    mem_wr   = push_i & ~(out_free & ~mem_has);
  end

  // Storage array write port (no reset so it can map to RAM)
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers, occupancy and the registered head word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
      if (out_free) begin
        if (mem_has) begin
          out_valid_q <= 1'b1;
          out_data_q  <= mem_q[rd_ptr_q];
        end else if (push_i) begin
          out_valid_q <= 1'b1;
          out_data_q  <= din_i;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign dout_o  = out_data_q;
  assign valid_o = out_valid_q;
  assign count_o = mem_cnt_q + CW'(out_valid_q);
  assign empty_o = ~out_valid_q;

endmodule

// File: rtl/task_enq_responder.sv
// Destination-tile responder: accepts remote task enqueue requests, offers each
// to the local task queue and returns exactly one ack/nack per request.
module task_enq_responder
  import chronos::*;
  import task_enq_responder_pkg::*;
#(
  parameter int RESP_FIFO_DEPTH = 8,
  parameter int NACK_WAIT       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  task_enq_responder_if.slave  enq_if,
  output logic                 empty
);

  localparam int CW  = $clog2(RESP_FIFO_DEPTH) + 1;
  localparam int WCW = $clog2(NACK_WAIT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(NACK_WAIT - 1);
  localparam logic [CW:0]    DEPTH_W   = (CW + 1)'(RESP_FIFO_DEPTH);

  enq_state_e     state_q, state_d;
  task_t          data_q;
  logic           tied_q;
  tsb_entry_id_t  tsb_q;
  tile_id_t       src_q;
  logic           reserved_q;
  logic [WCW-1:0] wait_cnt_q;

  logic           accept;
  logic           do_ack;
  logic           do_nack;
  logic           push;
  task_resp_t     push_data;
  logic           req_ready_int;
  logic [CW:0]    occupancy;

  logic [$bits(task_resp_t)-1:0] fifo_dout;
  logic                          fifo_valid;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_empty;
  task_resp_t                    head;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; TQ acceptance wins over a simultaneous full indication
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    do_ack  = 1'b0;
    do_nack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enq_if.req_valid && req_ready_int) begin
          accept  = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (enq_if.tq_enq_ready) begin
          do_ack  = 1'b1;
          state_d = ST_IDLE;
        end else if (tied_q && (enq_if.tq_full || wait_cnt_q == WAIT_LAST)) begin
          do_nack = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; a response slot is held from accept to push so the push never stalls
  always_comb begin
    occupancy            = {1'b0, fifo_count} + (CW + 1)'(reserved_q);
    req_ready_int        = (state_q == ST_IDLE) && (occupancy < DEPTH_W);
    enq_if.req_ready     = req_ready_int;
    enq_if.tq_enq_valid  = (state_q == ST_OFFER);
    enq_if.tq_enq_data   = data_q;
    enq_if.tq_enq_tied   = tied_q;
    push                 = do_ack | do_nack;
    push_data            = make_resp(do_ack, tsb_q, enq_if.tq_enq_epoch,
                                     enq_if.tq_enq_slot, src_q);
    empty                = (state_q == ST_IDLE) && fifo_empty;
  end

  // Latched request, reservation flag and the tied-task wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      tied_q     <= 1'b0;
      tsb_q      <= '0;
      src_q      <= '0;
      reserved_q <= 1'b0;
      wait_cnt_q <= '0;
    end else if (accept) begin
      data_q     <= enq_if.req_data;
      tied_q     <= enq_if.req_tied;
      tsb_q      <= enq_if.req_tsb_id;
      src_q      <= enq_if.req_src_tile;
      reserved_q <= 1'b1;
      wait_cnt_q <= '0;
    end else if (state_q == ST_OFFER) begin
      if (push) begin
        reserved_q <= 1'b0;
      end else if (wait_cnt_q != '1) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  task_enq_responder_fifo #(
    .WIDTH ($bits(task_resp_t)),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (enq_if.resp_ready),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign head                  = task_resp_t'(fifo_dout);
  assign enq_if.resp_valid     = fifo_valid;
  assign enq_if.resp_ack       = head.ack;
  assign enq_if.resp_tsb_id    = head.tsb_id;
  assign enq_if.resp_epoch     = head.epoch;
  assign enq_if.resp_tq_slot   = head.tq_slot;
  assign enq_if.resp_dest_tile = head.dest_tile;

endmodule

// File: tb/tb_task_enq_responder.sv
// Directed bench for the task-enqueue responder.
module tb_task_enq_responder;
  import chronos::*;

  logic clk = 1'b0;
  logic rst;
  logic empty;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task_enq_responder_if bus ();

  task_enq_responder #(
    .RESP_FIFO_DEPTH (8),
    .NACK_WAIT       (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enq_if (bus),
    .empty  (empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle; it is taken at the next edge
  task automatic send(input string tag, input logic tied, input logic [3:0] tsb,
                      input logic [3:0] src, input logic [31:0] data);
    bus.req_valid    = 1'b1;
    bus.req_tied     = tied;
    bus.req_tsb_id   = tsb;
    bus.req_src_tile = src;
    bus.req_data     = data;
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic ack, input logic [3:0] tsb,
                             input logic [7:0] epoch, input logic [5:0] slot,
                             input logic [3:0] dest);
    $display("txn %s valid=%0d ack=%0d tsb=%0d epoch=%0d slot=%0d dest=%0d", tag,
             bus.resp_valid, bus.resp_ack, bus.resp_tsb_id, bus.resp_epoch,
             bus.resp_tq_slot, bus.resp_dest_tile);
    check({tag, "_valid"}, bus.resp_valid, 1'b1);
    check({tag, "_ack"},   bus.resp_ack, ack);
    check({tag, "_tsb"},   bus.resp_tsb_id, tsb);
    check({tag, "_epoch"}, bus.resp_epoch, epoch);
    check({tag, "_slot"},  bus.resp_tq_slot, slot);
    check({tag, "_dest"},  bus.resp_dest_tile, dest);
  endtask

  initial begin
    int n;
    int got;
    logic acc;

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_data     = '0;
    bus.req_tied     = 1'b0;
    bus.req_tsb_id   = '0;
    bus.req_src_tile = '0;
    bus.tq_enq_ready = 1'b0;
    bus.tq_enq_slot  = '0;
    bus.tq_enq_epoch = '0;
    bus.tq_full      = 1'b0;
    bus.resp_ready   = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_tq_valid", bus.tq_enq_valid, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    rst = 1'b0;
    tick();
    check("rst_req_ready", bus.req_ready, 1'b1);

    // Single tied request acked immediately
    bus.tq_enq_ready = 1'b1;
    bus.tq_enq_slot  = 6'd12;
    bus.tq_enq_epoch = 8'd2;
    send("t1", 1'b1, 4'd5, 4'd3, 32'hA5A5_0001);
    check("t1_tq_valid", bus.tq_enq_valid, 1'b1);
    check("t1_tq_data", bus.tq_enq_data, 32'hA5A5_0001);
    check("t1_tq_tied", bus.tq_enq_tied, 1'b1);
    check("t1_req_ready_offer", bus.req_ready, 1'b0);
    check("t1_no_early_resp", bus.resp_valid, 1'b0);
    tick();
    expect_resp("t1", 1'b1, 4'd5, 8'd2, 6'd12, 4'd3);
    check("t1_tq_drop", bus.tq_enq_valid, 1'b0);
    bus.tq_enq_ready = 1'b0;
    tick();
    check("t1_empty", empty, 1'b1);

    // Tied request against a full TQ: nack without a TQ handshake
    bus.tq_full      = 1'b1;
    bus.tq_enq_slot  = 6'd7;
    bus.tq_enq_epoch = 8'd9;
    send("t2", 1'b1, 4'd6, 4'd1, 32'h0000_0002);
    check("t2_tq_valid", bus.tq_enq_valid, 1'b1);
    tick();
    expect_resp("t2", 1'b0, 4'd6, 8'd0, 6'd0, 4'd1);
    check("t2_tq_drop", bus.tq_enq_valid, 1'b0);
    bus.tq_full = 1'b0;
    tick();

    // Tied request on a stalled TQ: nack after NACK_WAIT offer cycles
    send("t3", 1'b1, 4'd7, 4'd2, 32'h0000_0003);
    n = 0;
    while (bus.tq_enq_valid && n < 100) begin
      n++;
      tick();
    end
    check("t3_offer_cycles", n, 16);
    expect_resp("t3", 1'b0, 4'd7, 8'd0, 6'd0, 4'd2);
    tick();

    // Untied request on a stalled TQ: waits, then acked at offer cycle 40
    send("t3u", 1'b0, 4'd8, 4'd4, 32'h0000_0004);
    n = 0;
    for (int i = 0; i < 39; i++) begin
      if (bus.tq_enq_valid && !bus.resp_valid) n++;
      tick();
    end
    check("t3u_wait_cycles", n, 39);
    check("t3u_still_offer", bus.tq_enq_valid, 1'b1);
    bus.tq_enq_ready = 1'b1;
    bus.tq_enq_slot  = 6'd33;
    bus.tq_enq_epoch = 8'd4;
    tick();
    expect_resp("t3u", 1'b1, 4'd8, 8'd4, 6'd33, 4'd4);
    bus.tq_enq_ready = 1'b0;
    tick();

    // Back-pressured responses: 8 fill the FIFO, the 9th waits for space
    bus.resp_ready   = 1'b0;
    bus.tq_enq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.tq_enq_slot  = 6'(20 + i);
      bus.tq_enq_epoch = 8'(40 + i);
      send("t4", 1'b1, 4'(i), 4'(i), 32'h1000 + 32'(i));
      tick();
    end
    check("t4_full_req_ready", bus.req_ready, 1'b0);
    check("t4_head_valid", bus.resp_valid, 1'b1);
    check("t4_head_tsb", bus.resp_tsb_id, 4'd0);
    bus.tq_enq_slot  = 6'd28;
    bus.tq_enq_epoch = 8'd48;
    bus.req_valid    = 1'b1;
    bus.req_tied     = 1'b1;
    bus.req_tsb_id   = 4'd8;
    bus.req_src_tile = 4'd8;
    bus.req_data     = 32'h1008;
    tick();
    tick();
    check("t4_blocked_req_ready", bus.req_ready, 1'b0);
    check("t4_head_stable", bus.resp_tsb_id, 4'd0);
    bus.resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 9; c++) begin
      if (bus.resp_valid) begin
        expect_resp("t4_drain", 1'b1, 4'(got), 8'(40 + got), 6'(20 + got), 4'(got));
        got++;
      end
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) bus.req_valid = 1'b0;
    end
    check("t4_delivered", got, 9);
    bus.req_valid    = 1'b0;
    bus.tq_enq_ready = 1'b0;
    tick();
    check("t4_empty", empty, 1'b1);

    // Ready and full together: ready wins
    bus.tq_enq_ready = 1'b1;
    bus.tq_full      = 1'b1;
    bus.tq_enq_slot  = 6'd50;
    bus.tq_enq_epoch = 8'd77;
    send("t5", 1'b1, 4'd9, 4'd5, 32'h0000_0005);
    tick();
    expect_resp("t5", 1'b1, 4'd9, 8'd77, 6'd50, 4'd5);
    bus.tq_enq_ready = 1'b0;
    bus.tq_full      = 1'b0;
    tick();

    // Reset while offering with three queued responses
    bus.resp_ready   = 1'b0;
    bus.tq_enq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tq_enq_slot  = 6'(i + 1);
      bus.tq_enq_epoch = 8'(i + 1);
      send("t6", 1'b1, 4'(10 + i), 4'd6, 32'h6000 + 32'(i));
      tick();
    end
    bus.tq_enq_ready = 1'b0;
    send("t6_hold", 1'b1, 4'd13, 4'd6, 32'h6003);
    check("t6_offer", bus.tq_enq_valid, 1'b1);
    check("t6_queued", bus.resp_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_rst_resp_valid", bus.resp_valid, 1'b0);
    check("t6_rst_tq_valid", bus.tq_enq_valid, 1'b0);
    check("t6_rst_empty", empty, 1'b1);
    rst = 1'b0;
    tick();
    bus.resp_ready   = 1'b1;
    bus.tq_enq_ready = 1'b1;
    bus.tq_enq_slot  = 6'd3;
    bus.tq_enq_epoch = 8'd5;
    send("t6_fresh", 1'b1, 4'd14, 4'd7, 32'h6004);
    tick();
    expect_resp("t6_fresh", 1'b1, 4'd14, 8'd5, 6'd3, 4'd7);
    bus.tq_enq_ready = 1'b0;
    tick();
    check("t6_final_empty", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
